// File: rtl/piso_serializer_pkg.sv
// Shared types and line levels for the framed PISO transmitter (piso_pkg).
package piso_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic LINE_IDLE   = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/piso_serializer_if.sv
// Load handshake and serial-line bundle between a word source and the PISO transmitter.
interface piso_serializer_if #(parameter int DATA_W = 8);
  logic [DATA_W-1:0] parallel_in;
  logic              msb_first;
  logic              load_valid;
  logic              load_ready;
  logic              serial_out;
  logic              busy;
  logic              frame_done;

  modport master (
    output parallel_in, msb_first, load_valid,
    input  load_ready, serial_out, busy, frame_done
  );

  modport slave (
    input  parallel_in, msb_first, load_valid,
    output load_ready, serial_out, busy, frame_done
  );
endinterface

// File: rtl/piso_serializer_bit_timer.sv
// Bit-period counter: bit_tick marks the last clock of each bit; cleared while disabled.
module piso_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic bit_tick
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset || !en)      cnt_q <= '0;
    else if (cnt_q == LAST) cnt_q <= '0;
    else                    cnt_q <= cnt_q + 1'b1;
  end

  assign bit_tick = en && (cnt_q == LAST);
endmodule

// File: rtl/piso_serializer.sv
// Framed parallel-in/serial-out transmitter: start, DATA_W bits, optional even parity, stop.
// Parity bit is built in only when PISO_SERIALIZER_PARITY_EN is defined.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  piso_serializer_if.slave bus
);
  localparam int IDX_W = $clog2(DATA_W + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              msb_q, msb_d;
  logic              bit_tick;
  logic              serial_q, serial_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef PISO_SERIALIZER_PARITY_EN
  logic              par_q, par_d;
`endif

  piso_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .en       (state_q != IDLE),
    .bit_tick (bit_tick)
  );

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      sh_q     <= '0;
      idx_q    <= '0;
      msb_q    <= 1'b0;
      serial_q <= LINE_IDLE;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      idx_q    <= idx_d;
      msb_q    <= msb_d;
      serial_q <= serial_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef PISO_SERIALIZER_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    idx_d   = idx_q;
    msb_d   = msb_q;
`ifdef PISO_SERIALIZER_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      IDLE: if (bus.load_valid) begin
        sh_d    = bus.parallel_in;
        msb_d   = bus.msb_first;
        idx_d   = '0;
`ifdef PISO_SERIALIZER_PARITY_EN
        par_d   = ^bus.parallel_in;
`endif
        state_d = START;
      end
      START: if (bit_tick) state_d = DATA;
      DATA: if (bit_tick) begin
        sh_d  = msb_q ? (sh_q << 1) : (sh_q >> 1);
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
`ifdef PISO_SERIALIZER_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef PISO_SERIALIZER_PARITY_EN
      PARITY: if (bit_tick) state_d = STOP;
`endif
      STOP: if (bit_tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every port comes straight off a flop
  always_comb begin
    serial_d = LINE_IDLE;
    ready_d  = 1'b0;
    busy_d   = 1'b1;
    done_d   = 1'b0;
    case (state_d)
      IDLE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
        done_d  = (state_q == STOP);
      end
      START:  serial_d = START_LEVEL;
      DATA:   serial_d = msb_d ? sh_d[DATA_W-1] : sh_d[0];
`ifdef PISO_SERIALIZER_PARITY_EN
      PARITY: serial_d = par_d;
`endif
      STOP:   serial_d = STOP_LEVEL;
      default: serial_d = LINE_IDLE;
    endcase
  end

  assign bus.serial_out = serial_q;
  assign bus.load_ready = ready_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;
endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer (DATA_W=8, CLKS_PER_BIT=4); honours PISO_SERIALIZER_PARITY_EN.
module tb_piso_serializer;
  localparam int CPB = 4;
`ifdef PISO_SERIALIZER_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int CYC = FB * CPB;

  logic clk, reset;
  piso_serializer_if #(.DATA_W(8)) bus ();

  piso_serializer #(.DATA_W(8), .CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic obs_line [128];
  logic obs_busy [128];
  logic obs_done [128];
  logic obs_rdy  [128];

  typedef struct {
    logic [7:0] data;
    logic       msb;
    logic [7:0] line;  // data bits in transmit order, leftmost first
    logic       par;
  } vec_t;
  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic capture(input int from, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      obs_line[from+i] = bus.serial_out;
      obs_busy[from+i] = bus.busy;
      obs_done[from+i] = bus.frame_done;
      obs_rdy[from+i]  = bus.load_ready;
    end
  endtask

  function automatic logic [63:0] build_wave(input logic [7:0] lb, input logic p);
    logic [11:0] fb;
    logic [63:0] w;
    int n;
    fb = '0;
    fb[0] = 1'b0;
    for (int i = 0; i < 8; i++) fb[1+i] = lb[7-i];
    n = 9;
`ifdef PISO_SERIALIZER_PARITY_EN
    fb[n] = p;
    n++;
`else
    fb[11] = p;
`endif
    fb[n] = 1'b1;
    w = '0;
    for (int k = 0; k < CYC; k++) w[k] = fb[k/CPB];
    return w;
  endfunction

  // Compare a CYC-cycle frame window starting at obs index 'base'
  task automatic chk_frame(input string name, input int base, input logic [7:0] lb, input logic p);
    logic [63:0] aw, ab, ad, mask;
    aw = '0; ab = '0; ad = '0;
    for (int k = 0; k < CYC; k++) begin
      aw[k] = obs_line[base+k];
      ab[k] = obs_busy[base+k];
      ad[k] = obs_done[base+k];
    end
    mask = (64'd1 << CYC) - 64'd1;
    chk({name, "_line"}, aw, build_wave(lb, p));
    chk({name, "_busy"}, ab, mask);
    chk({name, "_nodone"}, ad, 64'd0);
    // first idle cycle: {done,busy,serial,ready}
    chk({name, "_end"}, {60'd0, obs_done[base+CYC], obs_busy[base+CYC],
                         obs_line[base+CYC], obs_rdy[base+CYC]}, 64'b1011);
  endtask

  task automatic run_frame(input string name, input logic [7:0] d, input logic m,
                           input logic [7:0] lb, input logic p);
    @(negedge clk);
    bus.parallel_in = d;
    bus.msb_first   = m;
    bus.load_valid  = 1'b1;
    chk({name, "_ready"}, {63'd0, bus.load_ready}, 64'd1);
    @(posedge clk);
    #1;
    bus.load_valid  = 1'b0;
    bus.parallel_in = ~d;   // must not disturb the frame in flight
    bus.msb_first   = ~m;
    capture(0, CYC + 1);
    chk_frame(name, 0, lb, p);
  endtask

  initial begin
    logic [63:0] acc;

    vecs[0] = '{8'hC4, 1'b0, 8'b00100011, 1'b1};
    vecs[1] = '{8'hC4, 1'b1, 8'b11000100, 1'b1};
    vecs[2] = '{8'h00, 1'b0, 8'b00000000, 1'b0};
    vecs[3] = '{8'hA5, 1'b1, 8'b10100101, 1'b0};
    vecs[4] = '{8'h01, 1'b1, 8'b00000001, 1'b1};
    vecs[5] = '{8'h80, 1'b0, 8'b00000001, 1'b1};
    vecs[6] = '{8'hFF, 1'b0, 8'b11111111, 1'b0};
    vecs[7] = '{8'h96, 1'b0, 8'b01101001, 1'b0};

    reset = 1'b1;
    bus.parallel_in = '0;
    bus.msb_first   = 1'b0;
    bus.load_valid  = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", {60'd0, bus.serial_out, bus.load_ready, bus.busy, bus.frame_done}, 64'b1100);
    reset = 1'b0;

    for (int i = 0; i < 8; i++)
      run_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].msb, vecs[i].line, vecs[i].par);

    // Reset and load_valid together: reset wins
    @(negedge clk);
    reset = 1'b1;
    bus.parallel_in = 8'h3C;
    bus.load_valid  = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.load_valid = 1'b0;
    @(negedge clk);
    chk("rst_vs_load", {62'd0, bus.busy, bus.serial_out}, 64'b01);

    // Back-to-back frames with mid-frame input changes
    @(negedge clk);
    bus.parallel_in = 8'h55;
    bus.msb_first   = 1'b0;
    bus.load_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.parallel_in = 8'hAA;
    bus.msb_first   = 1'b1;
    capture(0, 12);
    bus.parallel_in = 8'h0F;
    bus.msb_first   = 1'b0;
    capture(12, CYC + 6 - 12);
    bus.load_valid  = 1'b0;
    capture(CYC + 6, CYC - 4);
    chk_frame("b2b_f1", 0, 8'b10101010, 1'b0);
    chk("b2b_gap_start", {63'd0, obs_line[CYC+1]}, 64'd0);
    chk_frame("b2b_f2", CYC + 1, 8'b11110000, 1'b0);

    // Reset during data bit 3
    @(negedge clk);
    bus.parallel_in = 8'h00;
    bus.msb_first   = 1'b0;
    bus.load_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.load_valid = 1'b0;
    capture(0, 17);
    chk("midrst_bit3_low", {62'd0, obs_busy[16], obs_line[16]}, 64'b10);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    capture(0, 50);
    chk("midrst_after", {60'd0, obs_line[0], obs_rdy[0], obs_busy[0], obs_done[0]}, 64'b1100);
    acc = '0;
    for (int k = 0; k < 50; k++) acc[0] = acc[0] | obs_done[k] | obs_busy[k] | ~obs_line[k];
    chk("midrst_quiet", acc, 64'd0);
    run_frame("midrst_next", 8'hC4, 1'b1, 8'b11000100, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in, serial-out framed transmitter that drives the serial line consumed by the team's serial-in/parallel-out shift register. It accepts a parallel word through a valid/ready handshake and shifts it out as one frame:
- start bit (0)
- DATA_W data bits, MSB- or LSB-first, selected per word
- optional even parity bit
- stop bit (1)

Each bit is held for CLKS_PER_BIT clocks. The line idles high.

## Interface
Parameters:
- DATA_W, 8, payload width; at least 1.
- CLKS_PER_BIT, 4, clocks per serial bit; at least 1.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- parallel_in  in  DATA_W  word to transmit; captured on accept.
- msb_first  in  1  bit order: 1 = MSB-first, 0 = LSB-first; captured on accept.
- load_valid  in  1  word available on parallel_in.
- load_ready  out  1  transmitter can accept a word.
- serial_out  out  1  serial line; idles high.
- busy  out  1  a frame is in progress.
- frame_done  out  1  one-cycle pulse when a frame completes.

## Operation
- States: IDLE, START, DATA, PARITY (only with the macro), STOP.
- **IDLE:**
  - serial_out=1, load_ready=1, busy=0.
  - Accept occurs when load_valid && load_ready at a rising edge.
  - On accept: capture parallel_in into the shift register and capture msb_first, then go to START.
- **START:** serial_out=0 for CLKS_PER_BIT cycles, then go to DATA.
- **DATA:**
  - serial_out is the current shift-register head: bit DATA_W-1 when MSB-first, bit 0 when LSB-first.
  - After each CLKS_PER_BIT cycles, shift one position (left when MSB-first, right when LSB-first) and increment the bit index.
  - After bit DATA_W-1 has been sent, go to PARITY or STOP.
- **PARITY:** serial_out is the XOR of the captured word, held for CLKS_PER_BIT cycles.
- **STOP:** serial_out=1 for CLKS_PER_BIT cycles, then go to IDLE and pulse frame_done for one cycle.
- load_ready=0 and busy=1 in every state except IDLE.
- parallel_in, msb_first and load_valid are ignored outside IDLE. Changing them mid-frame does not alter the frame.
- The bit-period counter runs from 0 to CLKS_PER_BIT-1 and wraps. With CLKS_PER_BIT=1 it is constant 0 and each bit lasts exactly one cycle.
- The bit index is $clog2(DATA_W+1) bits wide and is compared against DATA_W-1; no overflow is possible.

## Timing
- Reset values: serial_out=1, load_ready=1, busy=0, frame_done=0, state=IDLE, counters=0, shift register=0.
- Reset mid-frame aborts immediately. The line is high from the next cycle, no frame_done pulse is issued, and the next accept may occur one cycle after reset deasserts.
- If an accept happens at edge N, serial_out first goes low in the cycle after edge N.
- Frame length: (DATA_W+2)×CLKS_PER_BIT cycles, or (DATA_W+3)×CLKS_PER_BIT with parity.
- frame_done is high in the first IDLE cycle, and load_ready is also 1 in that cycle.
- With load_valid held high, consecutive frames are separated by exactly one idle-high cycle (the accept cycle).
- If reset and load_valid are asserted in the same cycle, reset wins and the word is not accepted.
- All outputs are registered; there is no combinational path from any input to any output.

## Configuration
- Macro PISO_SERIALIZER_PARITY_EN.
  - Defined: the PARITY state exists and an even-parity bit is inserted between the data bits and the stop bit.
  - Undefined: the PARITY state and parity logic are removed and DATA goes directly to STOP.
- The default build leaves the macro undefined.

## Structure
- Package piso_pkg contains:
  - The state enum typedef (IDLE, START, DATA, PARITY, STOP).
  - Constants LINE_IDLE=1'b1, START_LEVEL=1'b0, STOP_LEVEL=1'b1.
- One sub-module, piso_bit_timer:
  - Inputs: clk, reset, an enable, and CLKS_PER_BIT.
  - Output: a bit_tick pulse on the last cycle of each bit period.
  - The counter clears whenever the enable is low; the FSM enables it in every non-IDLE state.

## Test plan
All scenarios use DATA_W=8 and CLKS_PER_BIT=4.
- **Reset:** hold reset for 3 cycles → serial_out=1, load_ready=1, busy=0, frame_done=0.
- **LSB-first, no parity:** send 0xC4 with msb_first=0 → line is 0 | 0,0,1,0,0,0,1,1 | 1, 4 cycles per bit. frame_done occurs 40 cycles after the first low cycle, busy is high for those 40 cycles.
- **MSB-first:** send 0xC4 with msb_first=1 → data bits are 1,1,0,0,0,1,0,0.
- **Parity build:** with PISO_SERIALIZER_PARITY_EN defined, send 0xC4 → parity bit 1 appears before the stop bit and the frame is 44 cycles long. Sending 0x00 gives a parity bit of 0.
- **Back-to-back and mid-frame changes:** hold load_valid high with 0x55 then 0x0F, and change parallel_in during frame 1 → frame 1 is unaffected. Exactly one idle-high cycle separates the frames, and frame 2 sends 0x0F.
- **Reset mid-frame:** assert reset during data bit 3 → serial_out=1 from the next cycle, no frame_done pulse, and a new word is accepted correctly afterwards.
